// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//   LED pattern sequencer for the board LED bank. A prescaler produces a
//   one-cycle advance strobe (a clock enable, not a derived clock). Each
//   advance either loads the starting pattern of a newly selected mode or
//   moves the current pattern by one step.
//
//   Modes: 00 binary count, 01 walking one, 10 bounce, 11 bar.
//
// Parameters
//   N_LED     number of LED outputs (>= 2)
//   TICK_DIV  clk cycles per automatic advance (>= 1)
//   PW        width of pos, derived from N_LED (do not override)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     1: prescaler drives advances, 0: manual step only
//   direction  1: up / left, 0: down (sampled at advance)
//   mode       display mode (sampled at advance)
//   step       one-cycle manual advance, honoured only when enable=0
//   leds       registered LED pattern
//   pos        position register used by walk / bounce / bar
//   tick       one-cycle pulse in the first cycle new leds are visible
//   wrap       pulse with tick when the step wrapped or reversed
// ---------------------------------------------------------------------------
module led_sequencer #(
    parameter int N_LED    = 16,
    parameter int TICK_DIV = 25000000,
    parameter int PW       = $clog2(N_LED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [N_LED-1:0] leds,
    output logic [PW-1:0]    pos,
    output logic             tick,
    output logic             wrap
);

    localparam logic [1:0] MODE_COUNT  = 2'b00;
    localparam logic [1:0] MODE_WALK   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BAR    = 2'b11;

    localparam logic BDIR_UP   = 1'b1;
    localparam logic BDIR_DOWN = 1'b0;

    // A one-bit prescaler is kept even for TICK_DIV=1; it then never leaves 0
    // and the compare against PS_LAST holds on every enabled cycle.
    localparam int             PSW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
    localparam logic [PSW-1:0] PS_ONE  = PSW'(1);

    localparam logic [PW-1:0]    POS_LAST = PW'(N_LED - 1);
    localparam logic [PW-1:0]    POS_ONE  = PW'(1);
    localparam logic [N_LED-1:0] CNT_ONE  = N_LED'(1);

    // -----------------------------------------------------------------------
    // Pattern helpers
    // -----------------------------------------------------------------------
    function automatic logic [N_LED-1:0] onehot_at(input logic [PW-1:0] p);
        logic [N_LED-1:0] o;
        o = '0;
        for (int i = 0; i < N_LED; i++) begin
            o[i] = (PW'(i) == p);
        end
        return o;
    endfunction

    function automatic logic [N_LED-1:0] bar_to(input logic [PW-1:0] p);
        logic [N_LED-1:0] o;
        o = '0;
        for (int i = 0; i < N_LED; i++) begin
            o[i] = (PW'(i) <= p);
        end
        return o;
    endfunction

    // -----------------------------------------------------------------------
    // Prescaler / advance strobe
    // -----------------------------------------------------------------------
    logic [PSW-1:0] prescaler;
    logic           adv;

    always_comb begin
        adv = enable ? (prescaler == PS_LAST) : step;
    end

    // Held at 0 while disabled so re-enabling always gives a full period
    // before the first automatic advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (!enable || (prescaler == PS_LAST)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Pattern state
    // -----------------------------------------------------------------------
    logic [N_LED-1:0] count;
    logic             bdir;
    logic [1:0]       mode_r;

    logic [N_LED-1:0] count_nx;
    logic [PW-1:0]    pos_nx;
    logic             bdir_nx;
    logic [1:0]       mode_nx;
    logic [N_LED-1:0] leds_nx;
    logic             wrap_nx;

    // Modulo-N_LED neighbours of pos; N_LED need not be a power of two.
    logic          pos_at_last;
    logic          pos_at_zero;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_dec;

    always_comb begin
        pos_at_last = (pos == POS_LAST);
        pos_at_zero = (pos == '0);
        pos_inc     = pos_at_last ? '0 : (pos + POS_ONE);
        pos_dec     = pos_at_zero ? POS_LAST : (pos - POS_ONE);
    end

    always_comb begin
        count_nx = count;
        pos_nx   = pos;
        bdir_nx  = bdir;
        mode_nx  = mode_r;
        leds_nx  = leds;
        wrap_nx  = 1'b0;

        if (mode != mode_r) begin
            // Mode switch: restart from the new mode's initial pattern, no step.
            mode_nx  = mode;
            count_nx = '0;
            pos_nx   = '0;
            bdir_nx  = BDIR_UP;
            leds_nx  = (mode == MODE_COUNT) ? '0 : onehot_at('0);
        end else begin
            case (mode_r)
                MODE_COUNT: begin
                    if (direction) begin
                        count_nx = count + CNT_ONE;
                        wrap_nx  = &count;
                    end else begin
                        count_nx = count - CNT_ONE;
                        wrap_nx  = (count == '0);
                    end
                    leds_nx = count_nx;
                end

                MODE_WALK: begin
                    pos_nx  = direction ? pos_inc : pos_dec;
                    wrap_nx = direction ? pos_at_last : pos_at_zero;
                    leds_nx = onehot_at(pos_nx);
                end

                MODE_BOUNCE: begin
                    // Reversal happens on the step leaving an end, so each end
                    // is shown exactly once per sweep.
                    if (bdir == BDIR_UP) begin
                        if (pos_at_last) begin
                            bdir_nx = BDIR_DOWN;
                            pos_nx  = pos - POS_ONE;
                            wrap_nx = 1'b1;
                        end else begin
                            pos_nx = pos + POS_ONE;
                        end
                    end else begin
                        if (pos_at_zero) begin
                            bdir_nx = BDIR_UP;
                            pos_nx  = POS_ONE;
                            wrap_nx = 1'b1;
                        end else begin
                            pos_nx = pos - POS_ONE;
                        end
                    end
                    leds_nx = onehot_at(pos_nx);
                end

                default: begin // MODE_BAR
                    pos_nx  = direction ? pos_inc : pos_dec;
                    wrap_nx = direction ? pos_at_last : pos_at_zero;
                    leds_nx = bar_to(pos_nx);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            pos    <= '0;
            bdir   <= BDIR_UP;
            mode_r <= MODE_COUNT;
            leds   <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            tick <= adv;
            wrap <= adv & wrap_nx;
            if (adv) begin
                count  <= count_nx;
                pos    <= pos_nx;
                bdir   <= bdir_nx;
                mode_r <= mode_nx;
                leds   <= leds_nx;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
//   Directed self-checking bench for led_sequencer with N_LED=4, TICK_DIV=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int N_LED    = 4;
    localparam int TICK_DIV = 3;
    localparam int PW       = 2;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             direction;
    logic [1:0]       mode;
    logic             step;
    logic [N_LED-1:0] leds;
    logic [PW-1:0]    pos;
    logic             tick;
    logic             wrap;

    int errors = 0;
    int checks = 0;

    led_sequencer #(
        .N_LED    (N_LED),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .direction (direction),
        .mode      (mode),
        .step      (step),
        .leds      (leds),
        .pos       (pos),
        .tick      (tick),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges with the given inputs, then releases it
    // 1 unit after an edge; the prescaler starts counting at the next edge.
    task automatic do_reset(input logic en, input logic [1:0] md, input logic dir);
        reset     = 1'b0;
        step      = 1'b0;
        enable    = en;
        mode      = md;
        direction = dir;
        clk_n(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 2'b01, 1'b1);
        reset = 1'b0;
        clk_n(1);
        checks++;
        if ({leds, pos, tick, wrap} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset_state got leds=%b pos=%0d tick=%b wrap=%b want 0000/0/0/0",
                     leds, pos, tick, wrap);
        end
    endtask

    task automatic test_walk();
        logic [3:0] exp_l [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset(1'b1, 2'b01, 1'b1);
        clk_n(2);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL walk_early_tick got tick=%b want 0", tick);
        end
        clk_n(1);
        checks++;
        if ({tick, wrap, leds} !== {1'b1, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL walk_load got tick=%b wrap=%b leds=%b want 1/0/0001", tick, wrap, leds);
        end
        for (int k = 0; k < 4; k++) begin
            clk_n(1);
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL walk_tick_width step %0d got tick=%b want 0", k, tick);
            end
            clk_n(2);
            checks++;
            if ({tick, wrap, leds} !== {1'b1, exp_w[k], exp_l[k]}) begin
                errors++;
                $display("FAIL walk_step %0d got tick=%b wrap=%b leds=%b want 1/%b/%b",
                         k, tick, wrap, leds, exp_w[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_p [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
        logic       exp_w [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_l;
        do_reset(1'b1, 2'b10, 1'b1);
        clk_n(3);
        checks++;
        if ({tick, wrap, pos, leds} !== {1'b1, 1'b0, 2'd0, 4'b0001}) begin
            errors++;
            $display("FAIL bounce_load got tick=%b wrap=%b pos=%0d leds=%b want 1/0/0/0001",
                     tick, wrap, pos, leds);
        end
        for (int k = 0; k < 7; k++) begin
            direction = ~direction;
            clk_n(3);
            exp_l = 4'b0001 << exp_p[k];
            checks++;
            if ({tick, wrap, pos, leds} !== {1'b1, exp_w[k], exp_p[k], exp_l}) begin
                errors++;
                $display("FAIL bounce_step %0d got tick=%b wrap=%b pos=%0d leds=%b want 1/%b/%0d/%b",
                         k, tick, wrap, pos, leds, exp_w[k], exp_p[k], exp_l);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_l [3] = '{4'b1111, 4'b1110, 4'b1101};
        logic       exp_w [3] = '{1'b1, 1'b0, 1'b0};
        do_reset(1'b1, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            clk_n(3);
            checks++;
            if ({tick, wrap, leds} !== {1'b1, exp_w[k], exp_l[k]}) begin
                errors++;
                $display("FAIL count_down %0d got tick=%b wrap=%b leds=%b want 1/%b/%b",
                         k, tick, wrap, leds, exp_w[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_manual_step();
        logic [3:0] exp_l [3] = '{4'b0001, 4'b0010, 4'b0100};
        do_reset(1'b0, 2'b01, 1'b1);
        clk_n(4);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL step_idle got tick=%b want 0", tick);
        end
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            clk_n(1);
            step = 1'b0;
            checks++;
            if ({tick, leds} !== {1'b1, exp_l[k]}) begin
                errors++;
                $display("FAIL step_adv %0d got tick=%b leds=%b want 1/%b", k, tick, leds, exp_l[k]);
            end
            clk_n(2);
            checks++;
            if ({tick, leds} !== {1'b0, exp_l[k]}) begin
                errors++;
                $display("FAIL step_gap %0d got tick=%b leds=%b want 0/%b", k, tick, leds, exp_l[k]);
            end
        end
        // step must be ignored once enabled; the prescaler starts from 0.
        enable = 1'b1;
        step   = 1'b1;
        clk_n(1);
        step = 1'b0;
        checks++;
        if ({tick, leds} !== {1'b0, 4'b0100}) begin
            errors++;
            $display("FAIL step_ignored got tick=%b leds=%b want 0/0100", tick, leds);
        end
        clk_n(1);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL step_presc_hold got tick=%b want 0", tick);
        end
        clk_n(1);
        checks++;
        if ({tick, leds} !== {1'b1, 4'b1000}) begin
            errors++;
            $display("FAIL step_reenable got tick=%b leds=%b want 1/1000", tick, leds);
        end
    endtask

    task automatic test_bar();
        logic [3:0] exp_l [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b1111, 4'b0111};
        logic       exp_w [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset(1'b1, 2'b11, 1'b1);
        for (int k = 0; k < 7; k++) begin
            if (k == 5) direction = 1'b0;
            clk_n(3);
            checks++;
            if ({tick, wrap, leds} !== {1'b1, exp_w[k], exp_l[k]}) begin
                errors++;
                $display("FAIL bar_step %0d got tick=%b wrap=%b leds=%b want 1/%b/%b",
                         k, tick, wrap, leds, exp_w[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 2'b01, 1'b1);
        clk_n(6);
        checks++;
        if ({tick, pos, leds} !== {1'b1, 2'd1, 4'b0010}) begin
            errors++;
            $display("FAIL areset_pre got tick=%b pos=%0d leds=%b want 1/1/0010", tick, pos, leds);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({leds, pos, tick, wrap} !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL areset_now got leds=%b pos=%0d tick=%b wrap=%b want 0000/0/0/0",
                     leds, pos, tick, wrap);
        end
        clk_n(1);
        reset = 1'b1;
        clk_n(2);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_early got tick=%b want 0", tick);
        end
        clk_n(1);
        checks++;
        if ({tick, wrap, leds} !== {1'b1, 1'b0, 4'b0001}) begin
            errors++;
            $display("FAIL areset_first got tick=%b wrap=%b leds=%b want 1/0/0001", tick, wrap, leds);
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        direction = 1'b0;
        mode      = 2'b00;
        step      = 1'b0;
        test_reset();
        test_walk();
        test_bounce();
        test_count_down();
        test_manual_step();
        test_bar();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
